// File: rtl/cpu7_ifu_fcl_pkg.sv
// Shared types for the cpu7 IFU fetch control: FSM encoding, watchdog default
// and the pc_bf select request/response structs.
package cpu7_ifu_fcl_pkg;

  typedef enum logic [1:0] {
    FCL_INIT  = 2'd0,
    FCL_RUN   = 2'd1,
    FCL_DRAIN = 2'd2
  } fcl_state_e;

  localparam int unsigned FCL_TIMEOUT_DEF = 255;

  // Inputs to the pc_bf priority encoder, highest priority first.
  typedef struct packed {
    logic init;
    logic exc;
    logic ertn;
    logic br;
    logic adv;
  } pcsel_req_t;

  // Active-low one-hot pc_bf selects.
  typedef struct packed {
    logic init_l;
    logic old_l;
    logic pcinc_l;
    logic brpc_l;
    logic excpc_l;
    logic ertnpc_l;
  } pcsel_t;

  localparam pcsel_t PCSEL_NONE = '1;

endpackage

// File: rtl/cpu7_ifu_fcl_pcsel.sv
// Priority encoder from fetch-control events to the active-low one-hot pc_bf
// selects; exactly one select is low in every cycle.
module cpu7_ifu_fcl_pcsel
  import cpu7_ifu_fcl_pkg::*;
(
  input  pcsel_req_t req_i,
  output pcsel_t     sel_o
);

  always_comb begin
    sel_o = PCSEL_NONE;
    if (req_i.init)      sel_o.init_l   = 1'b0;
    else if (req_i.exc)  sel_o.excpc_l  = 1'b0;
    else if (req_i.ertn) sel_o.ertnpc_l = 1'b0;
    else if (req_i.br)   sel_o.brpc_l   = 1'b0;
    else if (req_i.adv)  sel_o.pcinc_l  = 1'b0;
    else                 sel_o.old_l    = 1'b0;
  end

endmodule

// File: rtl/cpu7_ifu_fcl.sv
// cpu7 IFU fetch control: single-outstanding instruction-bus handshake,
// stale-return discard after redirects, pc_bf selects and fetch watchdog.
module cpu7_ifu_fcl
  import cpu7_ifu_fcl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = FCL_TIMEOUT_DEF
) (
  input  logic clock,
  input  logic resetn,
  output logic inst_req,
  input  logic inst_addr_ok,
  input  logic inst_valid,
  output logic inst_cancel,
  input  logic br_taken,
  input  logic exu_ifu_except,
  input  logic exu_ifu_ertn_e,
  input  logic exu_ifu_stall_req,
  output logic fcl_fdp_pcbf_sel_init_l,
  output logic fcl_fdp_pcbf_sel_old_l,
  output logic fcl_fdp_pcbf_sel_pcinc_l,
  output logic fcl_fdp_pcbf_sel_brpc_l,
  output logic fcl_fdp_pcbf_sel_excpc_l,
  output logic fcl_fdp_pcbf_sel_ertnpc_l,
  output logic fcl_fdp_dec_valid,
  output logic fcl_fdp_pc_f2d_en,
  output logic fcl_exu_fetch_timeout
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  fcl_state_e      state_q, state_d;
  logic            outst_q, outst_d;
  logic            drop_q,  drop_d;
  logic [WD_W-1:0] wd_q,    wd_d;

  logic running, redirect, hs, ret, live, adv, fire;
  pcsel_req_t sel_req;
  pcsel_t     sel;

  assign running  = (state_q != FCL_INIT);
  assign redirect = running & (exu_ifu_except | exu_ifu_ertn_e | br_taken);
  // A returning fetch frees the slot in the same cycle, so the next request overlaps it.
  assign inst_req = running & (~outst_q | inst_valid);
  assign hs       = inst_req & inst_addr_ok;
  assign ret      = running & inst_valid & outst_q;
  assign live     = ret & ~drop_q & ~redirect;
  assign adv      = live & ~exu_ifu_stall_req;
  assign fire     = running & outst_q & ~inst_valid & (wd_q == WD_LAST);

  assign inst_cancel           = redirect | fire;
  assign fcl_fdp_dec_valid     = adv;
  assign fcl_fdp_pc_f2d_en     = adv;
  assign fcl_exu_fetch_timeout = fire;

  assign sel_req = '{init: ~running, exc: exu_ifu_except, ertn: exu_ifu_ertn_e,
                     br: br_taken, adv: adv};

  cpu7_ifu_fcl_pcsel u_pcsel (
    .req_i (sel_req),
    .sel_o (sel)
  );

  assign fcl_fdp_pcbf_sel_init_l   = sel.init_l;
  assign fcl_fdp_pcbf_sel_old_l    = sel.old_l;
  assign fcl_fdp_pcbf_sel_pcinc_l  = sel.pcinc_l;
  assign fcl_fdp_pcbf_sel_brpc_l   = sel.brpc_l;
  assign fcl_fdp_pcbf_sel_excpc_l  = sel.excpc_l;
  assign fcl_fdp_pcbf_sel_ertnpc_l = sel.ertnpc_l;

  always_comb begin
    state_d = state_q;
    outst_d = outst_q;
    drop_d  = drop_q;
    wd_d    = '0;
    if (!running) begin
      state_d = FCL_RUN;
    end else begin
      if (hs)       outst_d = 1'b1;
      else if (ret) outst_d = 1'b0;
      // An older fetch still in flight at a redirect becomes stale; a later
      // redirect merges into that same single stale fetch.
      if (redirect) drop_d = outst_q & ~inst_valid;
      else if (ret) drop_d = 1'b0;
      if (outst_q & ~inst_valid) wd_d = wd_q + WD_W'(1);
      if (fire) begin
        outst_d = 1'b0;
        drop_d  = 1'b0;
        wd_d    = '0;
      end
      state_d = drop_d ? FCL_DRAIN : FCL_RUN;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= FCL_INIT;
      outst_q <= 1'b0;
      drop_q  <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      wd_q    <= wd_d;
    end
  end

endmodule
